// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the quad-SPI flash pad arbiter.
//   arbState_t : arbiter FSM states
//   owner_t    : which master currently drives the pads
//   IDLE_*     : pad values while nobody owns the bus (CS high, pads released)
//   SPI_*      : fixed lane drive for the single-bit SPI master
package flash_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OWN_SPI  = 2'd1,
      ST_OWN_QSPI = 2'd2,
      ST_GUARD    = 2'd3
   } arbState_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_SPI  = 2'd1,
      OWN_QSPI = 2'd2
   } owner_t;

   localparam logic       IDLE_CS_N = 1'b1;
   localparam logic       IDLE_SCK  = 1'b0;
   localparam logic [3:0] IDLE_DOUT = 4'b0000;
   localparam logic [3:0] IDLE_OE   = 4'b0000;

   // Lane order {HOLD, WP, MISO, MOSI}: the SPI master keeps HOLD/WP
   // driven high, leaves MISO as an input and drives MOSI.
   localparam logic [3:0] SPI_OE         = 4'b1101;
   localparam logic [2:0] SPI_DOUT_UPPER = 3'b110;

   function automatic owner_t stateOwner(input arbState_t st);
      owner_t own;
      own = OWN_NONE;
      if (st == ST_OWN_SPI)  own = OWN_SPI;
      if (st == ST_OWN_QSPI) own = OWN_QSPI;
      return own;
   endfunction

endpackage

// File: rtl/flash_pad_mux.sv
// Combinational owner-to-pad mux. Only the current owner's pins reach the
// flash pads, and only the owner sees pad inputs returned.
//   iOwner                       : current bus owner
//   iSPI_CS_N/SCK/MOSI           : SPI master pins
//   iQSPI_NCS/DCLK/DATAOUT/DATAOE: QSPI controller pins
//   iFLASH_DIN                   : pad inputs
//   oFLASH_CS_N/SCK/DOUT/OE      : pad drive
//   oSPI_MISO, oQSPI_DATAIN      : returned read data, zero when not owner
module flash_pad_mux
   import flash_arb_pkg::*;
(
   input  owner_t     iOwner,
   input  logic       iSPI_CS_N,
   input  logic       iSPI_SCK,
   input  logic       iSPI_MOSI,
   input  logic       iQSPI_NCS,
   input  logic       iQSPI_DCLK,
   input  logic [3:0] iQSPI_DATAOUT,
   input  logic [3:0] iQSPI_DATAOE,
   input  logic [3:0] iFLASH_DIN,
   output logic       oFLASH_CS_N,
   output logic       oFLASH_SCK,
   output logic [3:0] oFLASH_DOUT,
   output logic [3:0] oFLASH_OE,
   output logic       oSPI_MISO,
   output logic [3:0] oQSPI_DATAIN
);

   // QSPI lane enables are forced off whenever its chip select is high so a
   // deselected controller can never fight the flash on the data lanes.
   logic [3:0] qspiOe;
   for (genvar gi = 0; gi < 4; gi++) begin : gLane
      assign qspiOe[gi] = iQSPI_DATAOE[gi] & ~iQSPI_NCS;
   end

   always_comb begin
      oFLASH_CS_N  = IDLE_CS_N;
      oFLASH_SCK   = IDLE_SCK;
      oFLASH_DOUT  = IDLE_DOUT;
      oFLASH_OE    = IDLE_OE;
      oSPI_MISO    = 1'b0;
      oQSPI_DATAIN = 4'b0000;
      case (iOwner)
         OWN_SPI: begin
            oFLASH_CS_N = iSPI_CS_N;
            oFLASH_SCK  = iSPI_SCK & ~iSPI_CS_N;
            oFLASH_DOUT = {SPI_DOUT_UPPER, iSPI_MOSI};
            oFLASH_OE   = SPI_OE;
            oSPI_MISO   = iFLASH_DIN[1];
         end
         OWN_QSPI: begin
            oFLASH_CS_N  = iQSPI_NCS;
            oFLASH_SCK   = iQSPI_DCLK & ~iQSPI_NCS;
            oFLASH_DOUT  = iQSPI_DATAOUT;
            oFLASH_OE    = qspiOe;
            oQSPI_DATAIN = iFLASH_DIN;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Grants the shared quad-SPI flash pads to either the SPI master or the QSPI
// controller, enforces a CS-high guard interval between owners and forcibly
// releases an idle owner that keeps the other side waiting too long.
//   iCLK, iRESET            : clock (wMEM_CLK domain), sync active-high reset
//   iSPI_REQ / oSPI_GNT     : SPI master request / grant
//   iQSPI_REQ / oQSPI_GNT   : QSPI controller request / grant
//   SPI/QSPI pins, pad pins : see flash_pad_mux
//   oBUSY                   : arbiter not idle
//   oTIMEOUT                : one-cycle pulse in the first guard cycle of a
//                             forced release
module flash_bus_arbiter
   import flash_arb_pkg::*;
#(
   parameter int GUARD_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       iCLK,
   input  logic       iRESET,
   input  logic       iSPI_REQ,
   output logic       oSPI_GNT,
   input  logic       iSPI_CS_N,
   input  logic       iSPI_SCK,
   input  logic       iSPI_MOSI,
   output logic       oSPI_MISO,
   input  logic       iQSPI_REQ,
   output logic       oQSPI_GNT,
   input  logic       iQSPI_NCS,
   input  logic       iQSPI_DCLK,
   input  logic [3:0] iQSPI_DATAOUT,
   input  logic [3:0] iQSPI_DATAOE,
   output logic [3:0] oQSPI_DATAIN,
   output logic       oFLASH_CS_N,
   output logic       oFLASH_SCK,
   output logic [3:0] oFLASH_DOUT,
   output logic [3:0] oFLASH_OE,
   input  logic [3:0] iFLASH_DIN,
   output logic       oBUSY,
   output logic       oTIMEOUT
);

   localparam int              TO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX     = {TO_W{1'b1}};
   localparam logic [7:0]      GUARD_LAST = 8'(GUARD_CYCLES - 1);

   arbState_t       rState, nState;
   owner_t          rLast, nLast;
   logic [TO_W-1:0] rToCnt, nToCnt;
   logic [7:0]      rGuardCnt, nGuardCnt;
   logic            rSpiMask, nSpiMask;
   logic            rQspiMask, nQspiMask;
   logic            rTimeout, nTimeout;

   // A side that was forcibly released stays out of arbitration until it
   // drops its request once.
   logic spiReq, qspiReq;
   assign spiReq  = iSPI_REQ  & ~rSpiMask;
   assign qspiReq = iQSPI_REQ & ~rQspiMask;

   // Owner-relative view of the request/CS lines, so both OWN states share
   // one release/timeout path.
   logic ownerCsN, ownerReq, otherReq;
   always_comb begin
      ownerCsN = 1'b1;
      ownerReq = 1'b0;
      otherReq = 1'b0;
      if (rState == ST_OWN_SPI) begin
         ownerCsN = iSPI_CS_N;
         ownerReq = iSPI_REQ;
         otherReq = qspiReq;
      end else if (rState == ST_OWN_QSPI) begin
         ownerCsN = iQSPI_NCS;
         ownerReq = iQSPI_REQ;
         otherReq = spiReq;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         rState    <= ST_IDLE;
         rLast     <= OWN_QSPI;
         rToCnt    <= '0;
         rGuardCnt <= '0;
         rSpiMask  <= 1'b0;
         rQspiMask <= 1'b0;
         rTimeout  <= 1'b0;
      end else begin
         rState    <= nState;
         rLast     <= nLast;
         rToCnt    <= nToCnt;
         rGuardCnt <= nGuardCnt;
         rSpiMask  <= nSpiMask;
         rQspiMask <= nQspiMask;
         rTimeout  <= nTimeout;
      end
   end

   always_comb begin
      nState    = rState;
      nLast     = rLast;
      nToCnt    = '0;
      nGuardCnt = '0;
      nTimeout  = 1'b0;
      nSpiMask  = rSpiMask & iSPI_REQ;
      nQspiMask = rQspiMask & iQSPI_REQ;
      case (rState)
         ST_IDLE: begin
            // On a tie the side not served last wins.
            if (spiReq && (!qspiReq || rLast == OWN_QSPI)) begin
               nState = ST_OWN_SPI;
               nLast  = OWN_SPI;
            end else if (qspiReq) begin
               nState = ST_OWN_QSPI;
               nLast  = OWN_QSPI;
            end
         end
         ST_OWN_SPI, ST_OWN_QSPI: begin
            // Dropping REQ mid-transfer is ignored until CS_N goes high.
            if (!ownerReq && ownerCsN) begin
               nState = ST_GUARD;
            end else if (ownerCsN && otherReq) begin
               if (TIMEOUT_EN && rToCnt == TO_LAST) begin
                  nState   = ST_GUARD;
                  nTimeout = 1'b1;
                  if (rState == ST_OWN_SPI) nSpiMask = 1'b1;
                  else                      nQspiMask = 1'b1;
               end else begin
                  nToCnt = (rToCnt == TO_MAX) ? rToCnt : rToCnt + TO_W'(1);
               end
            end
         end
         ST_GUARD: begin
            if (rGuardCnt == GUARD_LAST) nState = ST_IDLE;
            else                          nGuardCnt = rGuardCnt + 8'd1;
         end
         default: nState = ST_IDLE;
      endcase
   end

   assign oSPI_GNT  = (rState == ST_OWN_SPI);
   assign oQSPI_GNT = (rState == ST_OWN_QSPI);
   assign oBUSY     = (rState != ST_IDLE);
   assign oTIMEOUT  = rTimeout;

   flash_pad_mux uPadMux (
      .iOwner        (stateOwner(rState)),
      .iSPI_CS_N     (iSPI_CS_N),
      .iSPI_SCK      (iSPI_SCK),
      .iSPI_MOSI     (iSPI_MOSI),
      .iQSPI_NCS     (iQSPI_NCS),
      .iQSPI_DCLK    (iQSPI_DCLK),
      .iQSPI_DATAOUT (iQSPI_DATAOUT),
      .iQSPI_DATAOE  (iQSPI_DATAOE),
      .iFLASH_DIN    (iFLASH_DIN),
      .oFLASH_CS_N   (oFLASH_CS_N),
      .oFLASH_SCK    (oFLASH_SCK),
      .oFLASH_DOUT   (oFLASH_DOUT),
      .oFLASH_OE     (oFLASH_OE),
      .oSPI_MISO     (oSPI_MISO),
      .oQSPI_DATAIN  (oQSPI_DATAIN)
   );

endmodule

// File: tb/tb_flash_bus_arbiter.sv
module tb_flash_bus_arbiter;

   logic       iCLK = 1'b0;
   logic       iRESET;
   logic       iSPI_REQ, iSPI_CS_N, iSPI_SCK, iSPI_MOSI;
   logic       iQSPI_REQ, iQSPI_NCS, iQSPI_DCLK;
   logic [3:0] iQSPI_DATAOUT, iQSPI_DATAOE, iFLASH_DIN;
   logic       oSPI_GNT, oSPI_MISO, oQSPI_GNT, oFLASH_CS_N, oFLASH_SCK, oBUSY, oTIMEOUT;
   logic [3:0] oQSPI_DATAIN, oFLASH_DOUT, oFLASH_OE;

   flash_bus_arbiter #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
      .iCLK(iCLK), .iRESET(iRESET),
      .iSPI_REQ(iSPI_REQ), .oSPI_GNT(oSPI_GNT),
      .iSPI_CS_N(iSPI_CS_N), .iSPI_SCK(iSPI_SCK), .iSPI_MOSI(iSPI_MOSI),
      .oSPI_MISO(oSPI_MISO),
      .iQSPI_REQ(iQSPI_REQ), .oQSPI_GNT(oQSPI_GNT),
      .iQSPI_NCS(iQSPI_NCS), .iQSPI_DCLK(iQSPI_DCLK),
      .iQSPI_DATAOUT(iQSPI_DATAOUT), .iQSPI_DATAOE(iQSPI_DATAOE),
      .oQSPI_DATAIN(oQSPI_DATAIN),
      .oFLASH_CS_N(oFLASH_CS_N), .oFLASH_SCK(oFLASH_SCK),
      .oFLASH_DOUT(oFLASH_DOUT), .oFLASH_OE(oFLASH_OE),
      .iFLASH_DIN(iFLASH_DIN),
      .oBUSY(oBUSY), .oTIMEOUT(oTIMEOUT)
   );

   always #5 iCLK = ~iCLK;

   localparam int S_SGNT = 0, S_QGNT = 1, S_BUSY = 2, S_TO = 3, S_CSN = 4;
   localparam int S_SCK = 5, S_DOUT = 6, S_OE = 7, S_MISO = 8, S_QDIN = 9;

   typedef struct {
      string      tag;
      int         sig;
      logic [3:0] exp;
   } expEntry_t;

   expEntry_t sbQ[$];
   int        checkCnt = 0;
   int        passCnt  = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs === exp) passCnt++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] obsSig(input int sig);
      case (sig)
         S_SGNT:  return {3'b000, oSPI_GNT};
         S_QGNT:  return {3'b000, oQSPI_GNT};
         S_BUSY:  return {3'b000, oBUSY};
         S_TO:    return {3'b000, oTIMEOUT};
         S_CSN:   return {3'b000, oFLASH_CS_N};
         S_SCK:   return {3'b000, oFLASH_SCK};
         S_DOUT:  return oFLASH_DOUT;
         S_OE:    return oFLASH_OE;
         S_MISO:  return {3'b000, oSPI_MISO};
         S_QDIN:  return oQSPI_DATAIN;
         default: return 4'hF;
      endcase
   endfunction

   task automatic expectSig(input string tag, input int sig, input logic [3:0] exp);
      expEntry_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = exp;
      sbQ.push_back(e);
   endtask

   // Let driven inputs settle, then drain the scoreboard against the outputs.
   task automatic verify();
      expEntry_t e;
      #1;
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkVal(e.tag, 32'(obsSig(e.sig)), 32'(e.exp));
      end
   endtask

   task automatic cycle();
      @(posedge iCLK);
      #2;
   endtask

   task automatic expectResetOutputs(input string tag);
      expectSig({tag, "_sgnt"}, S_SGNT, 4'h0);
      expectSig({tag, "_qgnt"}, S_QGNT, 4'h0);
      expectSig({tag, "_busy"}, S_BUSY, 4'h0);
      expectSig({tag, "_to"},   S_TO,   4'h0);
      expectSig({tag, "_csn"},  S_CSN,  4'h1);
      expectSig({tag, "_sck"},  S_SCK,  4'h0);
      expectSig({tag, "_dout"}, S_DOUT, 4'h0);
      expectSig({tag, "_oe"},   S_OE,   4'h0);
      expectSig({tag, "_miso"}, S_MISO, 4'h0);
      expectSig({tag, "_qdin"}, S_QDIN, 4'h0);
   endtask

   task automatic waitIdle(input string tag);
      for (int k = 0; k < 30 && oBUSY; k++) cycle();
      checkVal(tag, 32'(oBUSY), 32'd0);
   endtask

   task automatic doReset();
      iRESET = 1'b1;
      cycle();
      cycle();
      iRESET = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCnt, checkCnt);
      $fatal(1);
   end

   initial begin
      int gap;
      int cycles;
      iRESET = 1'b1;
      iSPI_REQ = 0; iSPI_CS_N = 1; iSPI_SCK = 0; iSPI_MOSI = 0;
      iQSPI_REQ = 0; iQSPI_NCS = 1; iQSPI_DCLK = 0;
      iQSPI_DATAOUT = 4'h0; iQSPI_DATAOE = 4'h0; iFLASH_DIN = 4'h0;

      // Reset state
      doReset();
      expectResetOutputs("rst");
      verify();
      $display("txn reset_values");

      // Single SPI transfer
      iSPI_REQ = 1;
      expectSig("spi_pre_gnt", S_SGNT, 4'h0);
      verify();
      cycle();
      expectSig("spi_gnt", S_SGNT, 4'h1);
      expectSig("spi_oe", S_OE, 4'b1101);
      expectSig("spi_busy", S_BUSY, 4'h1);
      verify();
      iSPI_CS_N = 0; iFLASH_DIN = 4'b0010;
      expectSig("spi_csn", S_CSN, 4'h0);
      expectSig("spi_miso", S_MISO, 4'h1);
      expectSig("spi_qdin", S_QDIN, 4'h0);
      verify();
      for (int i = 0; i < 8; i++) begin
         iSPI_SCK = 1; iSPI_MOSI = i[0];
         expectSig("spi_sck_hi", S_SCK, 4'h1);
         expectSig("spi_dout", S_DOUT, {3'b110, i[0]});
         verify();
         cycle();
         iSPI_SCK = 0;
         expectSig("spi_sck_lo", S_SCK, 4'h0);
         verify();
         cycle();
      end
      iSPI_REQ = 0; iSPI_CS_N = 1;
      expectSig("spi_rel_hold", S_SGNT, 4'h1);
      verify();
      cycle();
      expectSig("spi_rel_gnt", S_SGNT, 4'h0);
      expectSig("spi_rel_oe", S_OE, 4'h0);
      expectSig("spi_rel_to", S_TO, 4'h0);
      verify();
      for (int k = 0; k < 3; k++) begin
         cycle();
         expectSig("spi_guard_busy", S_BUSY, 4'h1);
         verify();
      end
      cycle();
      expectSig("spi_guard_done", S_BUSY, 4'h0);
      verify();
      $display("txn single_spi");

      // Tie after reset: SPI first, then QSPI after the guard gap
      doReset();
      iSPI_REQ = 1; iQSPI_REQ = 1;
      cycle();
      expectSig("tie_sgnt", S_SGNT, 4'h1);
      expectSig("tie_qgnt", S_QGNT, 4'h0);
      verify();
      iSPI_CS_N = 0;
      cycle();
      cycle();
      iSPI_REQ = 0; iSPI_CS_N = 1;
      cycle();
      gap = 0;
      for (int k = 0; k < 20 && !oQSPI_GNT; k++) begin
         if (!oSPI_GNT) gap++;
         cycle();
      end
      checkVal("tie_qgnt_after", 32'(oQSPI_GNT), 32'd1);
      checkVal("tie_gap", gap, 5);
      $display("txn tie_at_reset gap=%0d", gap);

      // QSPI quad drive while QSPI owns
      iQSPI_NCS = 0; iQSPI_DCLK = 1; iQSPI_DATAOE = 4'b1111;
      iQSPI_DATAOUT = 4'b1011; iFLASH_DIN = 4'b1010;
      expectSig("quad_oe", S_OE, 4'b1111);
      expectSig("quad_dout", S_DOUT, 4'b1011);
      expectSig("quad_sck", S_SCK, 4'h1);
      expectSig("quad_qdin", S_QDIN, 4'b1010);
      expectSig("quad_miso", S_MISO, 4'h0);
      verify();
      iQSPI_NCS = 1;
      expectSig("quad_oe_ncs", S_OE, 4'h0);
      expectSig("quad_sck_ncs", S_SCK, 4'h0);
      verify();
      iQSPI_REQ = 0; iQSPI_DCLK = 0; iQSPI_DATAOE = 4'h0;
      cycle();
      waitIdle("quad_idle");
      $display("txn qspi_quad");

      // SPI drops REQ while CS_N is still low
      iSPI_REQ = 1;
      cycle();
      iSPI_CS_N = 0;
      cycle();
      iSPI_REQ = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         expectSig("hold_gnt", S_SGNT, 4'h1);
         verify();
      end
      iSPI_CS_N = 1;
      cycle();
      expectSig("hold_release", S_SGNT, 4'h0);
      verify();
      waitIdle("hold_idle");
      $display("txn hold_on_cs");

      // Timeout: idle QSPI owner while SPI waits
      iQSPI_REQ = 1;
      cycle();
      expectSig("to_qgnt", S_QGNT, 4'h1);
      verify();
      iSPI_REQ = 1;
      cycles = 1;
      for (int k = 0; k < 40 && !oTIMEOUT; k++) begin
         cycle();
         cycles++;
      end
      checkVal("to_cycle", cycles, 17);
      expectSig("to_qgnt_drop", S_QGNT, 4'h0);
      verify();
      cycle();
      expectSig("to_pulse_end", S_TO, 4'h0);
      verify();
      for (int k = 0; k < 20 && !oSPI_GNT; k++) cycle();
      expectSig("to_spi_gnt", S_SGNT, 4'h1);
      verify();
      iSPI_REQ = 0;
      cycle();
      waitIdle("to_guard_idle");
      cycle();
      expectSig("to_masked_qgnt", S_QGNT, 4'h0);
      expectSig("to_masked_busy", S_BUSY, 4'h0);
      verify();
      iQSPI_REQ = 0;
      cycle();
      iQSPI_REQ = 1;
      cycle();
      expectSig("to_rearm_qgnt", S_QGNT, 4'h1);
      verify();
      $display("txn timeout cycles=%0d", cycles);

      // Reset while QSPI owns mid-transfer
      iQSPI_NCS = 0; iQSPI_DCLK = 1; iQSPI_DATAOE = 4'b1111; iFLASH_DIN = 4'b0110;
      expectSig("mid_oe", S_OE, 4'b1111);
      verify();
      iRESET = 1;
      cycle();
      expectResetOutputs("mid_rst");
      verify();
      iRESET = 0; iQSPI_REQ = 0; iQSPI_NCS = 1; iQSPI_DCLK = 0; iQSPI_DATAOE = 4'h0;
      $display("txn reset_mid_transfer");

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/flash_bus_arbiter.md
# flash_bus_arbiter

Arbitrates the single quad-SPI flash pad set between the Avalon SPI master (single-bit, flash_spi) and the QSPI controller (quad, qspi). It sits between those two system ports and the oFLASH_* / iFLASH_* pads and replaces ad-hoc combinational CS/SCK gating with an explicit grant. It also guarantees CS-high guard time between owners and recovers from a stalled owner by timeout.

## Interface
- GUARD_CYCLES, 4: cycles with CS_N high and all pads released between owners (1..255).
- TIMEOUT_CYCLES, 65535: idle-owner cycles before forced release while the other side waits; 0 disables.
- iCLK  in  1  system clock (wMEM_CLK domain).
- iRESET  in  1  synchronous, active-high reset.
- iSPI_REQ  in  1  SPI master requests the bus (level).
- oSPI_GNT  out  1  SPI master owns the bus.
- iSPI_CS_N, iSPI_SCK, iSPI_MOSI  in  1 each  SPI master pins.
- oSPI_MISO  out  1  iFLASH_DIN[1] while oSPI_GNT, else 0.
- iQSPI_REQ  in  1  QSPI controller requests the bus.
- oQSPI_GNT  out  1  QSPI controller owns the bus.
- iQSPI_NCS, iQSPI_DCLK  in  1 each  QSPI pins.
- iQSPI_DATAOUT, iQSPI_DATAOE  in  4 each  QSPI data and per-lane enable.
- oQSPI_DATAIN  out  4  iFLASH_DIN while oQSPI_GNT, else 4'b0000.
- oFLASH_CS_N, oFLASH_SCK  out  1 each  pad drive.
- oFLASH_DOUT, oFLASH_OE  out  4 each  pad data / enable; lane order {HOLD, WP, MISO, MOSI}.
- iFLASH_DIN  in  4  pad inputs.
- oBUSY  out  1  state is not IDLE.
- oTIMEOUT  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, OWN_SPI, OWN_QSPI, GUARD.
- IDLE: the single requester is granted. If both request, the side not served last wins. rLAST resets to QSPI, so SPI wins the first tie.
- OWN_x to GUARD: taken when the owner REQ is low and its CS_N is high in the same cycle.
  - REQ dropping while CS_N is low does not release; the grant holds until CS_N goes high.
- GUARD: counts GUARD_CYCLES, then goes to IDLE. Requests are ignored during GUARD.
- Timeout counter:
  - Increments in OWN_x while the other REQ is high and the owner CS_N is high.
  - Clears on owner CS_N low, on leaving OWN_x, or when the other REQ is low.
  - Reaching TIMEOUT_CYCLES moves to GUARD and pulses oTIMEOUT. The preempted side must deassert and reassert REQ to re-arm; while its REQ stays high after a forced release it is masked from arbitration.
- Pad mux, combinational from registered state:
  - IDLE/GUARD: CS_N=1, SCK=0, DOUT=0000, OE=0000.
  - OWN_SPI: CS_N=iSPI_CS_N, SCK=iSPI_SCK&!iSPI_CS_N, DOUT={1,1,0,MOSI}, OE=1101.
  - OWN_QSPI: CS_N=iQSPI_NCS, SCK=iQSPI_DCLK&!iQSPI_NCS, DOUT=DATAOUT, OE=DATAOE&{4{!NCS}}.
- A non-granted requester's pins never reach the pads.

## Timing
- Reset values: GNTs 0, oBUSY 0, oTIMEOUT 0, oFLASH_CS_N 1, SCK 0, DOUT/OE 0000, oSPI_MISO 0, oQSPI_DATAIN 0000. Resetting mid-transfer forces these on the cycle after the reset edge.
- Grant latency: REQ sampled high in IDLE at edge N, so GNT is high after edge N+1.
- Release: the release condition at edge N drops GNT after edge N+1 (state GUARD). IDLE is reached after GUARD_CYCLES more edges, and the earliest next GNT follows one edge later. The minimum CS-high gap between owners is GUARD_CYCLES+1 cycles.
- oTIMEOUT is high exactly in the first GUARD cycle of a forced release.
- A release and a new request in the same cycle are both honoured: release first, the new grant after GUARD.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

## Structure
- Package flash_arb_pkg: state enum, owner enum (OWN_NONE/OWN_SPI/OWN_QSPI), idle pad constants, SPI OE/DOUT constant.
- One sub-module, flash_pad_mux: purely combinational owner-to-pad/return mux. The FSM, counters and rLAST live in flash_bus_arbiter.

## Test plan
- Single SPI: REQ high, CS_N low for 8 SCK, then REQ low with CS_N high -> GNT after 1 cycle, OE=1101, pads mirror SPI, GNT low after 1 cycle, back to IDLE after 4 guard cycles.
- Tie at reset: both REQ high -> SPI granted. After release and guard, QSPI is granted and the observed CS_N-high gap is 5 cycles.
- Hold on CS: SPI drops REQ while CS_N is low for 10 more cycles -> GNT holds 10 cycles, releases the cycle after CS_N rises.
- Timeout with TIMEOUT_CYCLES=16: QSPI owns, NCS high, SPI waiting -> oTIMEOUT pulses once at cycle 17, SPI granted after guard, QSPI ignored until it re-requests.
- QSPI quad: DATAOE=1111, NCS low -> oFLASH_OE=1111, DOUT follows DATAOUT. Driving iFLASH_DIN=1010 gives oQSPI_DATAIN=1010 and oSPI_MISO=0.
- Reset while OWN_QSPI with NCS low -> next cycle all outputs at reset values, state IDLE.
